// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage placed directly after the PC register. For each PC it
// runs a single transaction on the instruction-side SRAM-like bus
// (req / addr_ok / data_ok). The fetched word is presented to decode through a
// one-entry output slot. The unit also drives the PC register's advance enable
// and handles pipeline flushes. A PC that is not word aligned is never sent on
// the bus. Instead it is reported as an address error (AdEL) through the slot.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   pc_i          current PC from the PC register
//   flush         pipeline flush (PC register loads the exception PC this cycle)
//   id_stall      decode cannot take the slot contents this cycle
//   pc_enable     advance the PC register (combinational, high on slot load)
//   inst_req      bus request, high only while waiting for address acceptance
//   inst_addr     bus address (the latched fetch PC)
//   inst_addr_ok  bus accepted the address
//   inst_rdata    bus read data
//   inst_data_ok  bus read data valid
//   if_valid      slot holds an instruction
//   if_pc         PC of the slot instruction
//   if_inst       slot instruction word (0 for AdEL)
//   if_adel       slot entry is a misaligned-fetch exception
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             flush,
    input  logic             id_stall,
    output logic             pc_enable,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    input  logic             inst_data_ok,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_inst,
    output logic             if_adel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_DISCARD
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_pc_q;
    logic             r_valid;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_inst;
    logic             r_adel;

    logic             w_slot_free;
    logic             w_drain;
    logic             w_misaligned;
    logic             w_start;
    logic             w_load_adel;
    logic             w_load_data;
    logic             w_load;

    // The slot can take a new entry if it is empty or is being drained now.
    assign w_slot_free  = !r_valid || !id_stall;
    assign w_drain      = r_valid && !id_stall;
    assign w_misaligned = (pc_i[1:0] != 2'b00);

    // -------------------------------------------------------------------------
    // Next-state and load decisions
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_load_adel  = 1'b0;
        w_load_data  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!flush && w_slot_free) begin
                    if (w_misaligned) begin
                        w_load_adel = 1'b1;
                    end else begin
                        w_start      = 1'b1;
                        w_next_state = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An accepted address always owes one data beat, so a flush
                // after acceptance must wait for and drop that beat.
                if (flush) begin
                    w_next_state = inst_addr_ok ? S_DISCARD : S_IDLE;
                end else if (inst_addr_ok) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (flush) begin
                    w_next_state = inst_data_ok ? S_IDLE : S_DISCARD;
                end else if (inst_data_ok) begin
                    w_load_data  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_DISCARD: begin
                // The owed beat is consumed even if another flush arrives with
                // it; waiting for a second beat would never complete.
                if (inst_data_ok) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_load    = w_load_adel || w_load_data;
    assign pc_enable = w_load && !rst;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Fetch address latch and output slot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q  <= RESET_PC;
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_adel  <= 1'b0;
        end else begin
            if (w_start) begin
                r_pc_q <= pc_i;
            end
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
                r_pc    <= w_load_adel ? pc_i : r_pc_q;
                r_inst  <= w_load_adel ? '0 : inst_rdata;
                r_adel  <= w_load_adel;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign inst_req  = (r_state == S_REQ);
    assign inst_addr = r_pc_q;
    assign if_valid  = r_valid;
    assign if_pc     = r_pc;
    assign if_inst   = r_inst;
    assign if_adel   = r_adel;

endmodule
